// File: rtl/dmg_irq_ctrl.sv
// Interrupt controller: latches peripheral request edges into IF, masks with IE,
// gates with IME and runs the acknowledge -> vector dispatch sequence for the CPU.
module dmg_irq_ctrl #(
    parameter int NUM_IRQ = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    input  logic               REG_SEL,
    input  logic               WR,
    input  logic               RD,
    input  logic [7:0]         DIN,
    output logic [7:0]         DOUT,
    input  logic               IME_SET,
    input  logic               IME_NOW,
    input  logic               IME_CLR,
    input  logic               INSN_END,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic               WAKE,
    output logic [7:0]         VECTOR,
    output logic               VEC_VALID
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_VEC   = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [NUM_IRQ-1:0] irq_d_r;
    logic [NUM_IRQ-1:0] if_r, if_s;
    logic [7:0]         ie_r, ie_s;
    logic               ime_r, ime_s;
    logic               ei_pend_r, ei_pend_s;
    logic [7:0]         dout_r, dout_s;
    logic [7:0]         vector_r, vector_s;
    logic               vec_valid_r, vec_valid_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] pending_s;
    logic               latch_s;

    // Isolates the lowest set (highest priority) bit of a request vector.
    function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] v);
        return v & (~v + {{(NUM_IRQ-1){1'b0}}, 1'b1});
    endfunction

    // Dispatch vector 0x40 + 8*n for the lowest set bit n, 0x00 when nothing is pending.
    function automatic logic [7:0] irq_vector(input logic [NUM_IRQ-1:0] v);
        logic [7:0] vec;
        vec = 8'h00;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                vec = 8'h40 + 8'(i * 8);
            end else begin
                vec = vec;
            end
        end
        return vec;
    endfunction

    assign rise_s    = IRQ_IN & ~irq_d_r;
    assign pending_s = if_r & ie_r[NUM_IRQ-1:0];
    assign latch_s   = (state_r == ST_LATCH);

    assign WAKE      = |pending_s;
    assign INT_REQ   = ime_r & (|pending_s) & (state_r == ST_IDLE);
    assign DOUT      = dout_r;
    assign VECTOR    = vector_r;
    assign VEC_VALID = vec_valid_r;

    // Dispatch sequencing: an ack in IDLE starts a fixed two-cycle LATCH/VEC run.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (INT_ACK) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATCH: state_s = ST_VEC;
            ST_VEC:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Register file next values; a hardware rise is OR-ed in last so it beats a clear.
    always_comb begin
        if_s = if_r;
        ie_s = ie_r;
        if (WR && !REG_SEL) begin
            if_s = DIN[NUM_IRQ-1:0];
        end else begin
            if_s = if_r;
        end
        if (latch_s) begin
            if_s = if_s & ~lowest_onehot(pending_s);
        end else begin
            if_s = if_s;
        end
        if_s = if_s | rise_s;
        if (WR && REG_SEL) begin
            ie_s = DIN;
        end else begin
            ie_s = ie_r;
        end
    end

    // Master enable: DI or dispatch clears, RETI sets now, EI arms for the next boundary.
    always_comb begin
        ime_s     = ime_r;
        ei_pend_s = ei_pend_r;
        if (IME_CLR || latch_s) begin
            ime_s     = 1'b0;
            ei_pend_s = 1'b0;
        end else begin
            if (INSN_END && ei_pend_r) begin
                ime_s     = 1'b1;
                ei_pend_s = 1'b0;
            end else begin
                ime_s     = ime_r;
                ei_pend_s = ei_pend_r;
            end
            if (IME_NOW) begin
                ime_s = 1'b1;
            end else if (IME_SET) begin
                ei_pend_s = 1'b1;
            end else begin
                ime_s = ime_s;
            end
        end
    end

    // Read data and dispatch vector; reads sample pre-write register contents.
    always_comb begin
        dout_s      = dout_r;
        vector_s    = vector_r;
        vec_valid_s = latch_s;
        if (RD) begin
            if (REG_SEL) begin
                dout_s = ie_r;
            end else begin
                dout_s = {{(8-NUM_IRQ){1'b1}}, if_r};
            end
        end else begin
            dout_s = dout_r;
        end
        if (latch_s) begin
            vector_s = irq_vector(pending_s);
        end else begin
            vector_s = vector_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            irq_d_r     <= '0;
            if_r        <= '0;
            ie_r        <= 8'h00;
            ime_r       <= 1'b0;
            ei_pend_r   <= 1'b0;
            dout_r      <= 8'h00;
            vector_r    <= 8'h00;
            vec_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            irq_d_r     <= IRQ_IN;
            if_r        <= if_s;
            ie_r        <= ie_s;
            ime_r       <= ime_s;
            ei_pend_r   <= ei_pend_s;
            dout_r      <= dout_s;
            vector_r    <= vector_s;
            vec_valid_r <= vec_valid_s;
        end
    end

endmodule

// File: tb/tb_dmg_irq_ctrl.sv
// Directed self-checking bench for dmg_irq_ctrl.
module tb_dmg_irq_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] IRQ_IN = 5'h00;
    logic       REG_SEL = 1'b0;
    logic       WR = 1'b0;
    logic       RD = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic [7:0] DOUT;
    logic       IME_SET = 1'b0;
    logic       IME_NOW = 1'b0;
    logic       IME_CLR = 1'b0;
    logic       INSN_END = 1'b0;
    logic       INT_ACK = 1'b0;
    logic       INT_REQ;
    logic       WAKE;
    logic [7:0] VECTOR;
    logic       VEC_VALID;

    int checks = 0;
    int failures = 0;

    dmg_irq_ctrl #(.NUM_IRQ(5)) dut (
        .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .REG_SEL(REG_SEL),
        .WR(WR), .RD(RD), .DIN(DIN), .DOUT(DOUT),
        .IME_SET(IME_SET), .IME_NOW(IME_NOW), .IME_CLR(IME_CLR),
        .INSN_END(INSN_END), .INT_ACK(INT_ACK), .INT_REQ(INT_REQ),
        .WAKE(WAKE), .VECTOR(VECTOR), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_reg(input logic sel, input logic [7:0] data);
        REG_SEL = sel; DIN = data; WR = 1'b1;
        step();
        WR = 1'b0;
    endtask

    task automatic rd_reg(input logic sel);
        REG_SEL = sel; RD = 1'b1;
        step();
        RD = 1'b0;
    endtask

    task automatic pulse_ime_now();
        IME_NOW = 1'b1;
        step();
        IME_NOW = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(); step();
        RESET = 1'b0;
        checks++;
        if ({DOUT, VECTOR, VEC_VALID, INT_REQ, WAKE} !== {8'h00, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h/%b%b%b exp=00/00/000", DOUT, VECTOR, VEC_VALID, INT_REQ, WAKE);
        end
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hE0) begin failures++; $display("FAIL reset_if got=%h exp=e0", DOUT); end
    endtask

    task automatic test_basic_dispatch();
        wr_reg(1'b1, 8'h01);
        pulse_ime_now();
        IRQ_IN[0] = 1'b1;
        step();
        checks++;
        if ({INT_REQ, WAKE} !== 2'b11) begin failures++; $display("FAIL basic_req got=%b%b exp=11", INT_REQ, WAKE); end
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        IRQ_IN[0] = 1'b0;
        checks++;
        if ({INT_REQ, VEC_VALID} !== 2'b00) begin failures++; $display("FAIL basic_t1 got=%b%b exp=00", INT_REQ, VEC_VALID); end
        step();
        checks++;
        if ({VEC_VALID, VECTOR, INT_REQ} !== {1'b1, 8'h40, 1'b0}) begin
            failures++; $display("FAIL basic_vec got=%b/%h/%b exp=1/40/0", VEC_VALID, VECTOR, INT_REQ);
        end
        step();
        checks++;
        if (VEC_VALID !== 1'b0) begin failures++; $display("FAIL basic_vv_once got=%b exp=0", VEC_VALID); end
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hE0) begin failures++; $display("FAIL basic_if_clr got=%h exp=e0", DOUT); end
        wr_reg(1'b0, 8'h01);
        checks++;
        if ({WAKE, INT_REQ} !== 2'b10) begin failures++; $display("FAIL basic_ime_clr got=%b%b exp=10", WAKE, INT_REQ); end
    endtask

    task automatic test_priority();
        wr_reg(1'b1, 8'h1F);
        wr_reg(1'b0, 8'h14);
        pulse_ime_now();
        checks++;
        if (INT_REQ !== 1'b1) begin failures++; $display("FAIL prio_req got=%b exp=1", INT_REQ); end
        INT_ACK = 1'b1;
        step();
        step();
        checks++;
        if ({VEC_VALID, VECTOR} !== {1'b1, 8'h50}) begin failures++; $display("FAIL prio_vec got=%b/%h exp=1/50", VEC_VALID, VECTOR); end
        step();
        INT_ACK = 1'b0;
        checks++;
        if (VEC_VALID !== 1'b0) begin failures++; $display("FAIL prio_ack_ignored got=%b exp=0", VEC_VALID); end
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hF0) begin failures++; $display("FAIL prio_if got=%h exp=f0", DOUT); end
    endtask

    task automatic test_reset_latch();
        wr_reg(1'b0, 8'h02);
        pulse_ime_now();
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++;
        if ({DOUT, VECTOR, VEC_VALID, INT_REQ, WAKE} !== {8'h00, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL rst_latch got=%h/%h/%b%b%b exp=00/00/000", DOUT, VECTOR, VEC_VALID, INT_REQ, WAKE);
        end
        step();
        checks++;
        if ({VEC_VALID, WAKE} !== 2'b00) begin failures++; $display("FAIL rst_latch_after got=%b%b exp=00", VEC_VALID, WAKE); end
    endtask

    task automatic test_halt_ei();
        wr_reg(1'b1, 8'h04);
        IRQ_IN[2] = 1'b1;
        step();
        IRQ_IN[2] = 1'b0;
        checks++;
        if ({WAKE, INT_REQ} !== 2'b10) begin failures++; $display("FAIL halt_wake got=%b%b exp=10", WAKE, INT_REQ); end
        IME_SET = 1'b1; INSN_END = 1'b1;
        step();
        IME_SET = 1'b0; INSN_END = 1'b0;
        step();
        checks++;
        if (INT_REQ !== 1'b0) begin failures++; $display("FAIL ei_first_end got=%b exp=0", INT_REQ); end
        INSN_END = 1'b1;
        step();
        INSN_END = 1'b0;
        checks++;
        if (INT_REQ !== 1'b1) begin failures++; $display("FAIL ei_second_end got=%b exp=1", INT_REQ); end
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        step();
        checks++;
        if ({VEC_VALID, VECTOR} !== {1'b1, 8'h50}) begin failures++; $display("FAIL halt_vec got=%b/%h exp=1/50", VEC_VALID, VECTOR); end
    endtask

    task automatic test_wr_race();
        IRQ_IN[3] = 1'b1;
        wr_reg(1'b0, 8'h00);
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hE8) begin failures++; $display("FAIL race_if got=%h exp=e8", DOUT); end
        wr_reg(1'b0, 8'h00);
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hE0) begin failures++; $display("FAIL held_level_once got=%h exp=e0", DOUT); end
        IRQ_IN[3] = 1'b0;
        step();
        IRQ_IN[3] = 1'b1;
        step();
        IRQ_IN[3] = 1'b0;
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hE8) begin failures++; $display("FAIL rearm_if got=%h exp=e8", DOUT); end
        REG_SEL = 1'b1; DIN = 8'hA5; WR = 1'b1; RD = 1'b1;
        step();
        WR = 1'b0; RD = 1'b0;
        checks++;
        if (DOUT !== 8'h04) begin failures++; $display("FAIL rd_wr_same got=%h exp=04", DOUT); end
        rd_reg(1'b1);
        checks++;
        if (DOUT !== 8'hA5) begin failures++; $display("FAIL ie_full8 got=%h exp=a5", DOUT); end
    endtask

    task automatic test_ie_in_ack();
        wr_reg(1'b0, 8'h01);
        wr_reg(1'b1, 8'h01);
        pulse_ime_now();
        REG_SEL = 1'b1; DIN = 8'h00; WR = 1'b1; INT_ACK = 1'b1;
        step();
        WR = 1'b0; INT_ACK = 1'b0;
        step();
        checks++;
        if ({VEC_VALID, VECTOR} !== {1'b1, 8'h00}) begin failures++; $display("FAIL ie_ack_vec got=%b/%h exp=1/00", VEC_VALID, VECTOR); end
        rd_reg(1'b0);
        checks++;
        if (DOUT !== 8'hE1) begin failures++; $display("FAIL ie_ack_if got=%h exp=e1", DOUT); end
        wr_reg(1'b1, 8'h01);
        checks++;
        if ({WAKE, INT_REQ} !== 2'b10) begin failures++; $display("FAIL ie_ack_ime got=%b%b exp=10", WAKE, INT_REQ); end
        IME_NOW = 1'b1; IME_CLR = 1'b1;
        step();
        IME_NOW = 1'b0; IME_CLR = 1'b0;
        checks++;
        if (INT_REQ !== 1'b0) begin failures++; $display("FAIL clr_over_now got=%b exp=0", INT_REQ); end
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_priority();
        test_reset_latch();
        test_halt_ei();
        test_wr_race();
        test_ie_in_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
